// File: rtl/jogo_pkg.sv
// Shared definitions for the round-control unit of the memory game.
// Holds the FSM state codes (also used by debug decoders on db_estado)
// and the width of the lives counter.
package jogo_pkg;

  localparam int unsigned VIDAS_W = 4;

  typedef enum logic [3:0] {
    inicial        = 4'd0,
    inicializa     = 4'd1,
    inicia_rodada  = 4'd2,
    espera         = 4'd4,
    registra       = 4'd5,
    compara        = 4'd6,
    proxima_jogada = 4'd7,
    proxima_rodada = 4'd8,
    perde_vida     = 4'd9,
    erro           = 4'd14,
    acerto         = 4'd15
  } estado_t;

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// contador_timeout: counts cycles while 'conta' is high, cleared by 'zera'
// or by reset (synchronous, active low). Saturates at M-1, where 'fim'
// is asserted.
// Ports: clock, reset (active low), zera (clear), conta (count enable),
//        fim (count reached M-1).
module contador_timeout #(
  parameter int unsigned M = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = (M > 2) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor;

  always_ff @(posedge clock) begin
    if (!reset || zera) begin
      valor <= '0;
    end else if (conta && valor != ULTIMO) begin
      valor <= valor + 1'b1;
    end
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas: Moore control FSM for the rounds of the memory
// game. Drives the play/round counters and play register, tracks lives and
// reports game-end status. All outputs decode from registered state only.
// Parameters: LIVES (1..15) errors tolerated; TIMEOUT_CYCLES (>=2) cycles
//             allowed in espera before a timeout.
// Inputs : clock, reset (synchronous, active low), iniciar, fimC, fimE,
//          jogada, igual.
// Outputs: zeraC, contaC, zeraE, contaE, zeraR, registraR, acertou, errou,
//          pronto, db_timeout, vidas[3:0], db_estado[3:0].
// Build option: define UNIDADE_CONTROLE_RODADAS_TIMEOUT_EN to enable the
// espera timeout; otherwise espera waits indefinitely and db_timeout is 0.
module unidade_controle_rodadas
  import jogo_pkg::*;
#(
  parameter int unsigned LIVES          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               fimC,
  input  logic               fimE,
  input  logic               jogada,
  input  logic               igual,
  output logic               zeraC,
  output logic               contaC,
  output logic               zeraE,
  output logic               contaE,
  output logic               zeraR,
  output logic               registraR,
  output logic               acertou,
  output logic               errou,
  output logic               pronto,
  output logic               db_timeout,
  output logic [VIDAS_W-1:0] vidas,
  output logic [3:0]         db_estado
);

  if (TIMEOUT_CYCLES < 2 || LIVES < 1 || LIVES > 15) begin : g_param_check
    $error("unidade_controle_rodadas: LIVES must be 1..15 and TIMEOUT_CYCLES >= 2");
  end

  estado_t            estado;
  logic [VIDAS_W-1:0] cnt_vidas;
  logic               timeout_fim;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= inicial;
    end else begin
      case (estado)
        inicial:        if (iniciar) estado <= inicializa;
        inicializa:     estado <= inicia_rodada;
        inicia_rodada:  estado <= espera;
        // a play arriving on the last allowed cycle wins over the timeout
        espera: begin
          if (jogada)           estado <= registra;
          else if (timeout_fim) estado <= perde_vida;
        end
        registra:       estado <= compara;
        compara: begin
          if (!igual)     estado <= perde_vida;
          else if (!fimC) estado <= proxima_jogada;
          else if (!fimE) estado <= proxima_rodada;
          else            estado <= acerto;
        end
        proxima_jogada: estado <= espera;
        proxima_rodada: estado <= inicia_rodada;
        // cnt_vidas still holds the pre-decrement value here
        perde_vida: begin
          if (cnt_vidas == VIDAS_W'(1)) estado <= erro;
          else                          estado <= inicia_rodada;
        end
        acerto, erro:   if (iniciar) estado <= inicializa;
        default:        estado <= inicial;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_vidas <= '0;
    end else if (estado == inicializa) begin
      cnt_vidas <= VIDAS_W'(LIVES);
    end else if (estado == perde_vida && cnt_vidas != '0) begin
      cnt_vidas <= cnt_vidas - 1'b1;
    end
  end

`ifdef UNIDADE_CONTROLE_RODADAS_TIMEOUT_EN
  logic em_espera;
  logic fora_espera;
  logic flag_timeout;

  assign em_espera   = (estado == espera);
  assign fora_espera = !em_espera;

  contador_timeout #(
    .M (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (fora_espera),
    .conta (em_espera),
    .fim   (timeout_fim)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      flag_timeout <= 1'b0;
    end else if (estado == inicializa) begin
      flag_timeout <= 1'b0;
    end else if (em_espera && !jogada && timeout_fim) begin
      flag_timeout <= 1'b1;
    end
  end

  assign db_timeout = flag_timeout;
`else
  assign timeout_fim = 1'b0;
  assign db_timeout  = 1'b0;
`endif

  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    pronto    = 1'b0;
    case (estado)
      inicial, inicializa: begin
        zeraC = 1'b1;
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      // replaying a round restarts the play counter but keeps the round
      inicia_rodada:  zeraC     = 1'b1;
      registra:       registraR = 1'b1;
      proxima_jogada: contaC    = 1'b1;
      proxima_rodada: contaE    = 1'b1;
      acerto: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      erro: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      default: ;
    endcase
  end

  assign vidas     = cnt_vidas;
  assign db_estado = estado;

endmodule
